// File: rtl/result_uart_pkg.sv
// Shared types and constants for the result UART transmitter.
// Holds the FSM state enum, ASCII byte constants and the line buffer sizing.
package result_uart_pkg;

    localparam int MAX_BYTES = 6;
    localparam int IDX_W     = $clog2(MAX_BYTES);

    typedef logic [IDX_W-1:0] idx_t;

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        SEND,
        GAP
    } state_e;

    localparam logic [7:0] ASC_0     = 8'h30;
    localparam logic [7:0] ASC_MINUS = 8'h2D;
    localparam logic [7:0] ASC_CR    = 8'h0D;
    localparam logic [7:0] ASC_LF    = 8'h0A;
    localparam logic [7:0] ASC_O     = 8'h4F;
    localparam logic [7:0] ASC_V     = 8'h56;
    localparam logic [7:0] ASC_F     = 8'h46;

    // Magnitude of a 9-bit two's complement value; -256 maps to 256.
    function automatic logic [8:0] abs9(input logic [8:0] v);
        return v[8] ? (~v + 9'd1) : v;
    endfunction

endpackage

// File: rtl/result_uart_tx_dec_digits.sv
// Serial binary-to-decimal converter: hundreds by repeated -100, then tens
// by repeated -10, remainder is units.
// Ports: clk_i, rst_i (async, active-high), start_i loads mag_i,
//        done_o (one cycle, digits valid), hund_o/tens_o/units_o.
module dec_digits (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       start_i,
    input  logic [8:0] mag_i,
    output logic       done_o,
    output logic [3:0] hund_o,
    output logic [3:0] tens_o,
    output logic [3:0] units_o
);

    logic       active_q, active_d;
    logic [8:0] rem_q, rem_d;
    logic [3:0] hund_q, hund_d;
    logic [3:0] tens_q, tens_d;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            active_q <= 1'b0;
            rem_q    <= '0;
            hund_q   <= '0;
            tens_q   <= '0;
        end else begin
            active_q <= active_d;
            rem_q    <= rem_d;
            hund_q   <= hund_d;
            tens_q   <= tens_d;
        end
    end

    // The hundreds test falls straight through to the tens test, so a
    // digit of zero costs no cycle; the final cycle is the done cycle.
    always_comb begin
        active_d = active_q;
        rem_d    = rem_q;
        hund_d   = hund_q;
        tens_d   = tens_q;
        if (start_i) begin
            active_d = 1'b1;
            rem_d    = mag_i;
            hund_d   = '0;
            tens_d   = '0;
        end else if (active_q) begin
            if (rem_q >= 9'd100) begin
                rem_d  = rem_q - 9'd100;
                hund_d = hund_q + 4'd1;
            end else if (rem_q >= 9'd10) begin
                rem_d  = rem_q - 9'd10;
                tens_d = tens_q + 4'd1;
            end else begin
                active_d = 1'b0;
            end
        end
    end

    always_comb begin
        done_o  = active_q && (rem_q < 9'd10);
        hund_o  = hund_q;
        tens_o  = tens_q;
        units_o = rem_q[3:0];
    end

endmodule

// File: rtl/result_uart_tx.sv
// Reports each ALU result as a signed decimal (or OVF) CR/LF line over the
// UART transmit strobe interface.
// Ports: hz100 clock, reset (async, active-high); result_ready/result/o_flag
//        capture; txready in, txdata/txclk strobe out; busy and dropped status.
module result_uart_tx
    import result_uart_pkg::*;
(
    input  logic       hz100,
    input  logic       reset,
    input  logic       result_ready,
    input  logic [8:0] result,
    input  logic       o_flag,
    input  logic       txready,
    output logic [7:0] txdata,
    output logic       txclk,
    output logic       busy,
    output logic       dropped
);

    state_e     state_q, state_d;
    logic [7:0] line_q [MAX_BYTES];
    logic [7:0] line_d [MAX_BYTES];
    idx_t       idx_q, idx_d;
    idx_t       last_q, last_d;
    logic       neg_q, neg_d;

    logic       accept;
    logic       conv_start;
    logic       conv_done;
    logic [3:0] hund;
    logic [3:0] tens;
    logic [3:0] units;
    idx_t       n;

    assign accept     = result_ready && (state_q == IDLE);
    assign conv_start = accept && !o_flag;

    dec_digits u_dec (
        .clk_i   (hz100),
        .rst_i   (reset),
        .start_i (conv_start),
        .mag_i   (abs9(result)),
        .done_o  (conv_done),
        .hund_o  (hund),
        .tens_o  (tens),
        .units_o (units)
    );

    always_ff @(posedge hz100 or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (result_ready) state_d = o_flag ? SEND : CONV;
            CONV: if (conv_done) state_d = SEND;
            SEND: if (txready) state_d = GAP;
            GAP:  state_d = (idx_q == last_q) ? IDLE : SEND;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge hz100 or posedge reset) begin
        if (reset) begin
            line_q <= '{default: 8'h00};
            idx_q  <= '0;
            last_q <= '0;
            neg_q  <= 1'b0;
        end else begin
            line_q <= line_d;
            idx_q  <= idx_d;
            last_q <= last_d;
            neg_q  <= neg_d;
        end
    end

    // Line assembly: n is the write cursor; leading zero digits are skipped
    // but the units digit is always written so that 0 prints as "0".
    always_comb begin
        line_d = line_q;
        idx_d  = idx_q;
        last_d = last_q;
        neg_d  = neg_q;
        n      = '0;
        if (accept) begin
            neg_d = result[8];
            idx_d = '0;
            if (o_flag) begin
                line_d    = '{default: 8'h00};
                line_d[0] = ASC_O;
                line_d[1] = ASC_V;
                line_d[2] = ASC_F;
                line_d[3] = ASC_CR;
                line_d[4] = ASC_LF;
                last_d    = idx_t'(4);
            end
        end else if (state_q == CONV && conv_done) begin
            line_d = '{default: 8'h00};
            if (neg_q) begin
                line_d[n] = ASC_MINUS;
                n = n + idx_t'(1);
            end
            if (hund != 4'd0) begin
                line_d[n] = ASC_0 + {4'd0, hund};
                n = n + idx_t'(1);
            end
            if (hund != 4'd0 || tens != 4'd0) begin
                line_d[n] = ASC_0 + {4'd0, tens};
                n = n + idx_t'(1);
            end
            line_d[n] = ASC_0 + {4'd0, units};
            n = n + idx_t'(1);
            line_d[n] = ASC_CR;
            n = n + idx_t'(1);
            line_d[n] = ASC_LF;
            last_d = n;
        end else if (state_q == GAP && idx_q != last_q) begin
            idx_d = idx_q + idx_t'(1);
        end
    end

    always_comb begin
        txclk   = (state_q == SEND) && txready;
        txdata  = txclk ? line_q[idx_q] : 8'h00;
        busy    = (state_q != IDLE);
        dropped = result_ready && busy;
    end

endmodule

// File: tb/tb_result_uart_tx.sv
// Self-checking bench for result_uart_tx: directed lines, collisions, reset
// abort and random lines against an arithmetic model of the expected text.
module tb_result_uart_tx;

    logic       hz100 = 1'b0;
    logic       reset;
    logic       result_ready;
    logic [8:0] result;
    logic       o_flag;
    logic       txready;
    logic [7:0] txdata;
    logic       txclk;
    logic       busy;
    logic       dropped;

    result_uart_tx dut (
        .hz100        (hz100),
        .reset        (reset),
        .result_ready (result_ready),
        .result       (result),
        .o_flag       (o_flag),
        .txready      (txready),
        .txdata       (txdata),
        .txclk        (txclk),
        .busy         (busy),
        .dropped      (dropped)
    );

    always #5 hz100 = ~hz100;

    int cyc = 0;
    always @(posedge hz100) cyc <= cyc + 1;

    logic [7:0] mon_b [$];
    int         mon_c [$];
    int         adj_cnt = 0;
    int         rdy_cnt = 0;
    int         drop_cnt = 0;
    logic       prev_clk = 1'b0;

    always @(negedge hz100) begin
        if (txclk === 1'b1) begin
            mon_b.push_back(txdata);
            mon_c.push_back(cyc);
            if (prev_clk === 1'b1) adj_cnt <= adj_cnt + 1;
            if (txready !== 1'b1) rdy_cnt <= rdy_cnt + 1;
        end
        if (dropped === 1'b1) drop_cnt <= drop_cnt + 1;
        prev_clk <= txclk;
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    logic [7:0] exp_q [$];
    int         exp_conv;

    // Expected line text and conversion latency from plain decimal arithmetic.
    task automatic model(input int v, input bit f);
        int m, h, t, u;
        exp_q.delete();
        exp_conv = 0;
        if (f) begin
            exp_q = '{8'h4F, 8'h56, 8'h46, 8'h0D, 8'h0A};
        end else begin
            m = (v < 0) ? -v : v;
            h = m / 100;
            t = (m / 10) % 10;
            u = m % 10;
            if (v < 0) exp_q.push_back(8'h2D);
            if (h > 0) exp_q.push_back(8'(48 + h));
            if (h > 0 || t > 0) exp_q.push_back(8'(48 + t));
            exp_q.push_back(8'(48 + u));
            exp_q.push_back(8'h0D);
            exp_q.push_back(8'h0A);
            exp_conv = 1 + h + t;
        end
    endtask

    task automatic run_line(input logic [8:0] r, input bit f,
                            input bit gaps, input int inj);
        int v, base, c0, fall, d0, a0, k0, lastc, obs;
        string nm;
        v = r[8] ? int'(r) - 512 : int'(r);
        nm = $sformatf("v%0d_f%0d_g%0d", v, f, gaps);
        model(v, f);
        base = mon_b.size();
        d0 = drop_cnt;
        a0 = adj_cnt;
        k0 = rdy_cnt;
        @(posedge hz100) #1;
        txready = gaps ? (cyc % 4 == 3) : 1'b1;
        result = r;
        o_flag = f;
        result_ready = 1'b1;
        c0 = cyc;
        fall = -1;
        for (int i = 1; i < 400; i++) begin
            @(posedge hz100) #1;
            if (gaps) txready = (cyc % 4 == 3);
            if (i == 1) chk({nm, "_busy_after_cap"}, int'(busy), 1);
            if (busy !== 1'b1) begin
                result_ready = 1'b0;
                fall = cyc;
                break;
            end
            result_ready = (i == inj);
            result = 9'($urandom);
            o_flag = 1'($urandom);
        end
        txready = 1'b1;
        chk({nm, "_busy_fall_in_time"}, int'(fall >= 0), 1);
        chk({nm, "_nbytes"}, mon_b.size() - base, exp_q.size());
        foreach (exp_q[k]) begin
            obs = (base + k < mon_b.size()) ? int'(mon_b[base + k]) : -1;
            chk($sformatf("%s_byte%0d", nm, k), obs, int'(exp_q[k]));
        end
        if (mon_b.size() > base) begin
            lastc = mon_c[mon_c.size() - 1];
            chk({nm, "_busy_fall_cycle"}, fall - lastc, 2);
            if (!gaps) begin
                chk({nm, "_first_strobe"}, mon_c[base] - c0, 1 + exp_conv);
                for (int k = base + 1; k < mon_c.size(); k++)
                    chk($sformatf("%s_spacing%0d", nm, k - base),
                        mon_c[k] - mon_c[k - 1], 2);
            end
        end
        chk({nm, "_adjacent"}, adj_cnt - a0, 0);
        chk({nm, "_strobe_not_ready"}, rdy_cnt - k0, 0);
        chk({nm, "_dropped"}, drop_cnt - d0, (inj > 0) ? 1 : 0);
        @(posedge hz100) #1;
        chk({nm, "_idle_after"}, int'(busy), 0);
    endtask

    initial begin
        int base;
        reset = 1'b1;
        result_ready = 1'b0;
        result = '0;
        o_flag = 1'b0;
        txready = 1'b1;
        #1;
        chk("rst_txdata", int'(txdata), 0);
        chk("rst_txclk", int'(txclk), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_dropped", int'(dropped), 0);
        repeat (2) @(posedge hz100);
        #1 reset = 1'b0;

        run_line(9'h07B, 1'b0, 1'b0, 0);
        run_line(9'h1FB, 1'b0, 1'b0, 0);
        run_line(9'h000, 1'b0, 1'b0, 0);
        run_line(9'h100, 1'b0, 1'b0, 0);
        run_line(9'h12B, 1'b0, 1'b0, 0);
        run_line(9'($urandom), 1'b1, 1'b0, 0);
        run_line(9'd42, 1'b0, 1'b1, 0);
        run_line(9'h07B, 1'b0, 1'b0, 7);
        run_line(9'h07B, 1'b0, 1'b0, 14);
        run_line(9'd55, 1'b0, 1'b0, 0);

        base = mon_b.size();
        @(posedge hz100) #1;
        result = 9'h07B;
        o_flag = 1'b0;
        result_ready = 1'b1;
        for (int i = 0; i < 60; i++) begin
            @(posedge hz100) #1;
            result_ready = 1'b0;
            if (mon_b.size() >= base + 2) break;
        end
        chk("abort_two_bytes_sent", mon_b.size() - base, 2);
        reset = 1'b1;
        #1;
        chk("abort_txdata", int'(txdata), 0);
        chk("abort_txclk", int'(txclk), 0);
        chk("abort_busy", int'(busy), 0);
        chk("abort_dropped", int'(dropped), 0);
        @(posedge hz100) #1;
        reset = 1'b0;
        base = mon_b.size();
        repeat (4) @(posedge hz100);
        #1;
        chk("abort_no_resend", mon_b.size() - base, 0);
        run_line(9'd7, 1'b0, 1'b0, 0);

        for (int j = 0; j < 12; j++)
            run_line(9'($urandom_range(0, 511)),
                     1'($urandom_range(0, 3) == 0),
                     1'($urandom_range(0, 1)), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
